// File: rtl/batch_controller_if.sv
// batch_controller_if
// Bundles every non-clock/reset signal of batch_controller.
//   master : the controller side (drives wload_*, start_scheduler, status).
//   slave  : the environment side (host, weight loader, scheduler).
// Signals:
//   start, num_batches            host -> controller, layer launch
//   wload_req, wload_addr         controller -> loader, reload request
//   wload_done                    loader -> controller, reload finished
//   start_scheduler, current_batch_id  controller -> scheduler
//   batch_complete, sched_done    scheduler -> controller
//   busy, layer_done, protocol_err  status
//   timeout_err                   status, only with BATCH_CTRL_WDOG_EN
//   dbg_state                     current FSM state, for observation
//
// Handshake: wload_req is a level held from the request until the cycle
// after wload_done is sampled; every other control signal is a one-cycle
// pulse sampled on the rising clock edge.  Nothing is ever back-pressured.
interface batch_controller_if #(
  parameter int WADDR_WIDTH = 16
);
  logic                   start;
  logic [3:0]             num_batches;
  logic                   wload_req;
  logic [WADDR_WIDTH-1:0] wload_addr;
  logic                   wload_done;
  logic                   start_scheduler;
  logic [2:0]             current_batch_id;
  logic                   batch_complete;
  logic                   sched_done;
  logic                   busy;
  logic                   layer_done;
  logic                   protocol_err;
`ifdef BATCH_CTRL_WDOG_EN
  logic                   timeout_err;
`endif
  logic [2:0]             dbg_state;

  modport master (
    input  start, num_batches, wload_done, batch_complete, sched_done,
    output wload_req, wload_addr, start_scheduler, current_batch_id,
           busy, layer_done, protocol_err, dbg_state
`ifdef BATCH_CTRL_WDOG_EN
    , output timeout_err
`endif
  );

  modport slave (
    output start, num_batches, wload_done, batch_complete, sched_done,
    input  wload_req, wload_addr, start_scheduler, current_batch_id,
           busy, layer_done, protocol_err, dbg_state
`ifdef BATCH_CTRL_WDOG_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/batch_controller.sv
// batch_controller
// Sequences one transpose-convolution layer: for each batch it requests a
// weight reload, starts the scheduler, waits for batch_complete/sched_done,
// then advances; after the last batch it pulses layer_done.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    batch_controller_if.master (see the interface for signal list)
// Optional feature: define BATCH_CTRL_WDOG_EN to add a 20-bit watchdog on
// LOAD_WAIT/SCHED_WAIT, the TIMEOUT_CYCLES parameter and timeout_err.
module batch_controller #(
  parameter int WADDR_WIDTH = 16,
  parameter int BATCH_WORDS = 1024
`ifdef BATCH_CTRL_WDOG_EN
  , parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  batch_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, SCHED_START, SCHED_WAIT, ADVANCE, FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             nb_q, nb_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   seen_bc_q, seen_bc_d;
  logic                   perr_q, perr_d;
  logic                   wload_req_q, wload_req_d;
  logic [WADDR_WIDTH-1:0] wload_addr_q, wload_addr_d;
  logic                   start_sched_q, start_sched_d;
  logic                   busy_q, busy_d;
  logic                   layer_done_q, layer_done_d;
`ifdef BATCH_CTRL_WDOG_EN
  logic [19:0]            wd_q, wd_d;
  logic                   terr_q, terr_d;
  logic                   waiting;
`endif

  always_comb begin
    state_d   = state_q;
    nb_d      = nb_q;
    cnt_d     = cnt_q;
    seen_bc_d = seen_bc_q;
    perr_d    = perr_q;
`ifdef BATCH_CTRL_WDOG_EN
    terr_d    = terr_q;
    wd_d      = wd_q;
    waiting   = (state_q == LOAD_WAIT) || (state_q == SCHED_WAIT);
`endif

    // Scheduler pulses are only meaningful while a batch is running.
    if ((state_q != SCHED_WAIT) && (bus.batch_complete || bus.sched_done)) begin
      perr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          nb_d   = ((bus.num_batches == 4'd0) || (bus.num_batches > 4'd8)) ?
                   4'd8 : bus.num_batches;
          cnt_d  = 3'd0;
          perr_d = 1'b0;
`ifdef BATCH_CTRL_WDOG_EN
          terr_d = 1'b0;
`endif
          state_d = LOAD_REQ;
        end
      end
      LOAD_REQ: state_d = LOAD_WAIT;
      LOAD_WAIT: begin
        if (bus.wload_done) state_d = SCHED_START;
      end
      SCHED_START: begin
        seen_bc_d = 1'b0;
        state_d   = SCHED_WAIT;
      end
      SCHED_WAIT: begin
        if (bus.batch_complete) seen_bc_d = 1'b1;
        if (bus.sched_done) begin
          // A batch_complete in the same cycle as sched_done is legal.
          if (!seen_bc_q && !bus.batch_complete) perr_d = 1'b1;
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if ({1'b0, cnt_q} == (nb_q - 4'd1)) begin
          state_d = FINISH;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = LOAD_REQ;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef BATCH_CTRL_WDOG_EN
    // Counter reads k during the k-th cycle (from 0) of a wait state, so
    // the limit fires at the end of cycle TIMEOUT_CYCLES of waiting.
    if (waiting && (wd_q == TIMEOUT_CYCLES - 20'd1)) begin
      terr_d  = 1'b1;
      state_d = IDLE;
    end
    if (((state_d == LOAD_WAIT) || (state_d == SCHED_WAIT)) && (state_d != state_q)) begin
      wd_d = 20'd0;
    end else if (waiting) begin
      wd_d = wd_q + 20'd1;
    end
`endif

    // Outputs are registered from the next state so they line up with it.
    // After a batch the request rises together with the new batch id;
    // from IDLE it rises one cycle after LOAD_REQ is entered.
    wload_req_d   = (state_d == LOAD_WAIT) ||
                    ((state_q == ADVANCE) && (state_d == LOAD_REQ));
    wload_addr_d  = WADDR_WIDTH'(int'(cnt_d) * BATCH_WORDS);
    start_sched_d = (state_q == SCHED_START);
    busy_d        = (state_d != IDLE);
    layer_done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      nb_q          <= 4'd0;
      cnt_q         <= 3'd0;
      seen_bc_q     <= 1'b0;
      perr_q        <= 1'b0;
      wload_req_q   <= 1'b0;
      wload_addr_q  <= '0;
      start_sched_q <= 1'b0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
`ifdef BATCH_CTRL_WDOG_EN
      wd_q          <= 20'd0;
      terr_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      nb_q          <= nb_d;
      cnt_q         <= cnt_d;
      seen_bc_q     <= seen_bc_d;
      perr_q        <= perr_d;
      wload_req_q   <= wload_req_d;
      wload_addr_q  <= wload_addr_d;
      start_sched_q <= start_sched_d;
      busy_q        <= busy_d;
      layer_done_q  <= layer_done_d;
`ifdef BATCH_CTRL_WDOG_EN
      wd_q          <= wd_d;
      terr_q        <= terr_d;
`endif
    end
  end

  assign bus.wload_req        = wload_req_q;
  assign bus.wload_addr       = wload_addr_q;
  assign bus.start_scheduler  = start_sched_q;
  assign bus.current_batch_id = cnt_q;
  assign bus.busy             = busy_q;
  assign bus.layer_done       = layer_done_q;
  assign bus.protocol_err     = perr_q;
  assign bus.dbg_state        = state_q;
`ifdef BATCH_CTRL_WDOG_EN
  assign bus.timeout_err      = terr_q;
`endif

endmodule

// File: tb/tb_batch_controller.sv
// tb_batch_controller
// Drives batch_controller with a randomized loader and scheduler model;
// expectations come from a per-run model of which batches should run.
module tb_batch_controller;

  localparam int WADDR_WIDTH = 16;
  localparam int BATCH_WORDS = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  batch_controller_if #(.WADDR_WIDTH(WADDR_WIDTH)) bus();

  batch_controller #(
    .WADDR_WIDTH(WADDR_WIDTH),
    .BATCH_WORDS(BATCH_WORDS)
`ifdef BATCH_CTRL_WDOG_EN
    , .TIMEOUT_CYCLES(20'd100)
`endif
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // ---------------- shared bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int req_due  = -1;
  int ld_cyc   = -1;
  int sd_cyc   = -1;
  int busy_chk_cyc = -1;
  int layer_cnt = 0;
  int ld_min = 1;
  int ld_max = 6;
  bit ld_en  = 1'b1;
  logic prev_req = 1'b0;
  logic prev_ss  = 1'b0;
  logic [1:0] sc_mode [8];   // 0 normal, 1 same-cycle bc+done, 2 done without bc

  logic [WADDR_WIDTH-1:0] exp_addr_q[$];
  logic [2:0]             exp_lid_q[$];
  logic [2:0]             exp_sid_q[$];
  logic [0:0]             exp_perr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int norm_batches(input logic [3:0] nb);
    return ((nb == 4'd0) || (nb > 4'd8)) ? 8 : int'(nb);
  endfunction

  task automatic flush_queues();
    exp_addr_q.delete();
    exp_lid_q.delete();
    exp_sid_q.delete();
    exp_perr_q.delete();
  endtask

  // ---------------- loader model ----------------
  initial begin : loader
    int d;
    bus.wload_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ld_en && bus.wload_req === 1'b1) begin
        d = $urandom_range(ld_max, ld_min);
        repeat (d) tick();
        bus.wload_done = 1'b1;
        ld_cyc = cyc;
        tick();
        bus.wload_done = 1'b0;
        while (bus.wload_req === 1'b1) @(negedge clk);
      end
    end
  end

  // ---------------- scheduler model ----------------
  initial begin : scheduler
    int d;
    int g;
    logic [1:0] m;
    bus.batch_complete = 1'b0;
    bus.sched_done     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.start_scheduler === 1'b1) begin
        m = sc_mode[bus.current_batch_id];
        d = $urandom_range(3, 0);
        g = $urandom_range(3, 0);
        repeat (d) tick();
        tick();
        if (m == 2'd0) begin
          bus.batch_complete = 1'b1;
          tick();
          bus.batch_complete = 1'b0;
          repeat (g) tick();
        end
        bus.batch_complete = (m == 2'd1);
        bus.sched_done     = 1'b1;
        sd_cyc  = cyc;
        req_due = cyc + 2;
        tick();
        bus.batch_complete = 1'b0;
        bus.sched_done     = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_req = 1'b0;
      prev_ss  = 1'b0;
    end else begin
      if (bus.wload_req && !prev_req) begin
        check("wload_req_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) begin
          check("wload_addr", bus.wload_addr, exp_addr_q.pop_front());
          check("load_batch_id", bus.current_batch_id, exp_lid_q.pop_front());
          check("wload_req_rise_cycle", cyc, req_due);
          check("busy_during_load", bus.busy, 1);
        end
      end
      if (bus.start_scheduler) begin
        check("start_sched_one_cycle", prev_ss, 0);
        if (!prev_ss) begin
          check("start_sched_expected", exp_sid_q.size() != 0, 1);
          if (exp_sid_q.size() != 0)
            check("sched_batch_id", bus.current_batch_id, exp_sid_q.pop_front());
          check("start_sched_cycle", cyc, ld_cyc + 2);
        end
      end
      if (bus.layer_done) begin
        layer_cnt++;
        check("layer_done_expected", exp_perr_q.size() != 0, 1);
        if (exp_perr_q.size() != 0)
          check("protocol_err_at_layer_done", bus.protocol_err, exp_perr_q.pop_front());
        check("layer_done_cycle", cyc, sd_cyc + 2);
        busy_chk_cyc = cyc + 1;
      end
      if (cyc == busy_chk_cyc) begin
        check("busy_low_after_layer", bus.busy, 0);
        check("layer_done_one_cycle", bus.layer_done, 0);
      end
      prev_req = bus.wload_req;
      prev_ss  = bus.start_scheduler;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_layer(input logic [3:0] nb, input logic [7:0] bad,
                             input logic [7:0] same, output int t);
    int  n;
    logic perr;
    n = norm_batches(nb);
    perr = 1'b0;
    for (int i = 0; i < 8; i++)
      sc_mode[i] = bad[i] ? 2'd2 : (same[i] ? 2'd1 : 2'd0);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(WADDR_WIDTH'((i * BATCH_WORDS) % (1 << WADDR_WIDTH)));
      exp_lid_q.push_back(3'(i));
      exp_sid_q.push_back(3'(i));
      if (bad[i]) perr = 1'b1;
    end
    exp_perr_q.push_back(perr);
    tick();
    bus.num_batches = nb;
    bus.start = 1'b1;
    t = cyc;
    req_due = cyc + 2;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_after_start", bus.busy, 1);
    check("protocol_err_cleared_by_start", bus.protocol_err, 0);
`ifdef BATCH_CTRL_WDOG_EN
    check("timeout_err_cleared_by_start", bus.timeout_err, 0);
`endif
  endtask

  task automatic run_layer(input logic [3:0] nb, input logic [7:0] bad, input logic [7:0] same);
    int t;
    int c0;
    int w;
    c0 = layer_cnt;
    start_layer(nb, bad, same, t);
    w = 0;
    while (layer_cnt == c0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("layer_done_seen", layer_cnt != c0, 1);
    repeat (3) @(negedge clk);
    check("all_loads_issued", exp_addr_q.size(), 0);
    check("all_sched_starts_issued", exp_sid_q.size(), 0);
    flush_queues();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int t;
    int w;
    logic [7:0] bad;
    logic [7:0] same;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.num_batches = 4'd0;
    for (int i = 0; i < 8; i++) sc_mode[i] = 2'd0;

    repeat (3) @(negedge clk);
    check("rst_wload_req", bus.wload_req, 0);
    check("rst_wload_addr", bus.wload_addr, 0);
    check("rst_start_scheduler", bus.start_scheduler, 0);
    check("rst_current_batch_id", bus.current_batch_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_layer_done", bus.layer_done, 0);
    check("rst_protocol_err", bus.protocol_err, 0);
`ifdef BATCH_CTRL_WDOG_EN
    check("rst_timeout_err", bus.timeout_err, 0);
`endif
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Full layer, loader acks after 5 cycles.
    ld_min = 5; ld_max = 5;
    run_layer(4'd8, 8'h00, 8'h00);
    ld_min = 1; ld_max = 6;

    // Normalization.
    run_layer(4'd0, 8'h00, 8'h00);
    run_layer(4'd3, 8'h00, 8'h00);
    run_layer(4'd12, 8'h00, 8'h00);

    // sched_done without batch_complete on batch 2.
    run_layer(4'd8, 8'h04, 8'h00);
    repeat (5) @(negedge clk);
    check("protocol_err_sticky", bus.protocol_err, 1);
    run_layer(4'd3, 8'h00, 8'h00);

    // Same-cycle batch_complete and sched_done.
    run_layer(4'd4, 8'h00, 8'hFF);

    // Random runs.
    for (int r = 0; r < 5; r++) begin
      bad = 8'h00;
      same = 8'(($urandom() & 32'hFF));
      for (int i = 0; i < 8; i++)
        if ($urandom_range(7, 0) == 0) bad[i] = 1'b1;
      run_layer(4'($urandom_range(15, 0)), bad, same);
    end

    // Reset during LOAD_WAIT of batch 4.
    ld_min = 6; ld_max = 6;
    start_layer(4'd8, 8'h00, 8'h00, t);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(bus.current_batch_id == 3'd4 && bus.wload_req === 1'b1) && w < 2000);
    check("reached_batch4_load", w < 2000, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wload_req", bus.wload_req, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_batch_id", bus.current_batch_id, 0);
    flush_queues();
    repeat (10) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    ld_min = 1; ld_max = 6;
    run_layer(4'd2, 8'h00, 8'h00);

`ifdef BATCH_CTRL_WDOG_EN
    // Withhold wload_done: watchdog fires after 100 cycles of LOAD_WAIT.
    ld_en = 1'b0;
    w = layer_cnt;
    start_layer(4'd1, 8'h00, 8'h00, t);
    exp_perr_q.delete();
    while (bus.timeout_err !== 1'b1 && cyc < t + 400) @(negedge clk);
    check("timeout_err_set", bus.timeout_err, 1);
    check("timeout_cycle", cyc, t + 102);
    check("timeout_wload_req_low", bus.wload_req, 0);
    check("timeout_busy_low", bus.busy, 0);
    repeat (5) @(negedge clk);
    check("timeout_no_layer_done", layer_cnt, w);
    check("timeout_err_sticky", bus.timeout_err, 1);
    flush_queues();
    ld_en = 1'b1;
    run_layer(4'd2, 8'h00, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : time_guard
    #500000;
    $display("FAIL time_guard: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "time limit");
  end

endmodule
